// File: rtl/stack_arbiter_if.sv
// Bundle of requester, status and RAM-side signals for stack_arbiter.
// Optional hwm signal exists only when STACK_ARBITER_HWM_EN is defined.
interface stack_arbiter_if #(
    parameter int DATA   = 32,
    parameter int ADDR_W = 16
);
    // Request/ack handshake: a requester raises req with op/wdata stable and
    // holds it until it samples ack=1 (a one-cycle pulse), then drops req on
    // that edge; req seen high in a later idle cycle is a new request.
    logic              req_a;
    logic [1:0]        op_a;
    logic [DATA-1:0]   wdata_a;
    logic              ack_a;
    logic [DATA-1:0]   rdata_a;

    logic              req_b;
    logic [1:0]        op_b;
    logic [DATA-1:0]   wdata_b;
    logic              ack_b;
    logic [DATA-1:0]   rdata_b;

    logic              err;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA-1:0]   ram_wdata;
    logic [DATA-1:0]   ram_rdata;

    logic [ADDR_W:0]   sp;
    logic              empty;
    logic              full;
`ifdef STACK_ARBITER_HWM_EN
    logic [ADDR_W:0]   hwm;
`endif

    modport slave (
        input  req_a, op_a, wdata_a,
        input  req_b, op_b, wdata_b,
        input  ram_rdata,
        output ack_a, rdata_a, ack_b, rdata_b, err,
        output ram_we, ram_addr, ram_wdata,
`ifdef STACK_ARBITER_HWM_EN
        output hwm,
`endif
        output sp, empty, full
    );

    modport master (
        output req_a, op_a, wdata_a,
        output req_b, op_b, wdata_b,
        output ram_rdata,
        input  ack_a, rdata_a, ack_b, rdata_b, err,
        input  ram_we, ram_addr, ram_wdata,
`ifdef STACK_ARBITER_HWM_EN
        input  hwm,
`endif
        input  sp, empty, full
    );
endinterface

// File: rtl/stack_arbiter.sv
// Two-port round-robin LIFO sequencer over a single-port, 1-cycle-latency RAM.
// Define STACK_ARBITER_HWM_EN to add the hwm (high-water mark) output.
module stack_arbiter #(
    parameter int DATA  = 32,
    parameter int DEPTH = 65536
) (
    input  logic             clk,
    input  logic             rst_n,
    stack_arbiter_if.slave   bus,
    output logic [2:0]       o_dbg_state
);
    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [1:0] OP_ILL  = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;

    localparam logic [ADDR_W:0]   SP_MAX   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   SP_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            r_state, w_state;
    logic [ADDR_W:0]   r_sp, w_sp;
    logic              r_empty, r_full;
    logic              r_last_b, w_last_b;
    logic              r_port_b, w_port_b;
    logic [1:0]        r_op, w_op;
    logic              r_err, w_err;
    logic              r_ack_a, w_ack_a;
    logic              r_ack_b, w_ack_b;
    logic              r_ram_we, w_ram_we;
    logic [ADDR_W-1:0] r_ram_addr, w_ram_addr;
    logic [DATA-1:0]   r_ram_wdata, w_ram_wdata;
    logic [DATA-1:0]   r_rdata_a, w_rdata_a;
    logic [DATA-1:0]   r_rdata_b, w_rdata_b;

    logic              w_req_any;
    logic              w_gnt_b;
    logic [1:0]        w_g_op;
    logic [DATA-1:0]   w_g_data;
    logic              w_reject;

    // B wins a tie only when A was granted last; r_last_b resets high so A wins first.
    always_comb begin
        w_req_any = bus.req_a | bus.req_b;
        w_gnt_b   = bus.req_b & (~bus.req_a | ~r_last_b);
        w_g_op    = w_gnt_b ? bus.op_b : bus.op_a;
        w_g_data  = w_gnt_b ? bus.wdata_b : bus.wdata_a;
        w_reject  = (w_g_op == OP_ILL)
                  | ((w_g_op == OP_PUSH) & r_full)
                  | ((w_g_op != OP_PUSH) & (w_g_op != OP_ILL) & r_empty);
    end

    always_comb begin
        w_state     = r_state;
        w_sp        = r_sp;
        w_last_b    = r_last_b;
        w_port_b    = r_port_b;
        w_op        = r_op;
        w_err       = 1'b0;
        w_ack_a     = 1'b0;
        w_ack_b     = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_addr  = r_ram_addr;
        w_ram_wdata = r_ram_wdata;
        w_rdata_a   = r_rdata_a;
        w_rdata_b   = r_rdata_b;

        case (r_state)
            S_IDLE: begin
                if (w_req_any) begin
                    w_last_b = w_gnt_b;
                    w_port_b = w_gnt_b;
                    w_op     = w_g_op;
                    if (w_reject) begin
                        w_state = S_DONE;
                        w_err   = 1'b1;
                        w_ack_a = ~w_gnt_b;
                        w_ack_b = w_gnt_b;
                    end else if (w_g_op == OP_PUSH) begin
                        // RAM outputs are registered, so they are loaded on the grant edge
                        // and are live during WRITE/READ.
                        w_state     = S_WRITE;
                        w_ram_we    = 1'b1;
                        w_ram_addr  = r_sp[ADDR_W-1:0];
                        w_ram_wdata = w_g_data;
                    end else begin
                        w_state    = S_READ;
                        w_ram_addr = r_sp[ADDR_W-1:0] - ADDR_ONE;
                    end
                end
            end
            S_WRITE: begin
                w_sp    = r_sp + SP_ONE;
                w_state = S_DONE;
                w_ack_a = ~r_port_b;
                w_ack_b = r_port_b;
            end
            S_READ: begin
                if (r_op == OP_POP) begin
                    w_sp = r_sp - SP_ONE;
                end
                w_state = S_WAIT;
            end
            S_WAIT: begin
                if (r_port_b) begin
                    w_rdata_b = bus.ram_rdata;
                end else begin
                    w_rdata_a = bus.ram_rdata;
                end
                w_state = S_DONE;
                w_ack_a = ~r_port_b;
                w_ack_b = r_port_b;
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sp        <= '0;
            r_empty     <= 1'b1;
            r_full      <= 1'b0;
            r_last_b    <= 1'b1;
            r_port_b    <= 1'b0;
            r_op        <= OP_ILL;
            r_err       <= 1'b0;
            r_ack_a     <= 1'b0;
            r_ack_b     <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_rdata_a   <= '0;
            r_rdata_b   <= '0;
        end else begin
            r_state     <= w_state;
            r_sp        <= w_sp;
            r_empty     <= (w_sp == '0);
            r_full      <= (w_sp == SP_MAX);
            r_last_b    <= w_last_b;
            r_port_b    <= w_port_b;
            r_op        <= w_op;
            r_err       <= w_err;
            r_ack_a     <= w_ack_a;
            r_ack_b     <= w_ack_b;
            r_ram_we    <= w_ram_we;
            r_ram_addr  <= w_ram_addr;
            r_ram_wdata <= w_ram_wdata;
            r_rdata_a   <= w_rdata_a;
            r_rdata_b   <= w_rdata_b;
        end
    end

`ifdef STACK_ARBITER_HWM_EN
    logic [ADDR_W:0] r_hwm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hwm <= '0;
        end else if (w_sp > r_hwm) begin
            r_hwm <= w_sp;
        end
    end

    assign bus.hwm = r_hwm;
`endif

    assign bus.ack_a     = r_ack_a;
    assign bus.ack_b     = r_ack_b;
    assign bus.rdata_a   = r_rdata_a;
    assign bus.rdata_b   = r_rdata_b;
    assign bus.err       = r_err;
    assign bus.ram_we    = r_ram_we;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_wdata = r_ram_wdata;
    assign bus.sp        = r_sp;
    assign bus.empty     = r_empty;
    assign bus.full      = r_full;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter: a full-depth instance and a DEPTH=4 instance,
// each with a behavioural 1-cycle-latency RAM.
module tb_stack_arbiter;
    localparam logic [1:0] OP_ILL  = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_PEEK = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stack_arbiter_if #(.DATA(32), .ADDR_W(16)) bus ();
    stack_arbiter_if #(.DATA(32), .ADDR_W(2))  sbus ();
    logic [2:0] dbg_state;
    logic [2:0] sdbg_state;

    stack_arbiter #(.DATA(32), .DEPTH(65536)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .o_dbg_state(dbg_state)
    );
    stack_arbiter #(.DATA(32), .DEPTH(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .bus(sbus), .o_dbg_state(sdbg_state)
    );

    logic [31:0] mem [0:65535];
    logic [31:0] smem [0:3];
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end
    always @(posedge clk) begin
        if (sbus.ram_we) smem[sbus.ram_addr] <= sbus.ram_wdata;
        sbus.ram_rdata <= smem[sbus.ram_addr];
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Results of the last do_op / arb_round call.
    int          o_lat;
    logic        o_err;
    logic [31:0] o_rd;
    int          o_we_cnt;
    logic [15:0] o_addr1;
    int          o_first;
    int          o_second;
    int          o_both;
    logic        o_first_err;

    // which: 0 = main port A, 1 = main port B, 2 = small-instance port A
    task automatic do_op(input int which, input logic [1:0] op, input logic [31:0] wd);
        int   cnt;
        bit   seen;
        logic ack, we, er;
        logic [31:0] rd;
        logic [15:0] addr;
        cnt = 0; seen = 0;
        o_lat = -1; o_err = 1'b0; o_rd = '0; o_we_cnt = 0; o_addr1 = '0;
        case (which)
            0: begin bus.req_a = 1'b1; bus.op_a = op; bus.wdata_a = wd; end
            1: begin bus.req_b = 1'b1; bus.op_b = op; bus.wdata_b = wd; end
            default: begin sbus.req_a = 1'b1; sbus.op_a = op; sbus.wdata_a = wd; end
        endcase
        while (!seen && cnt < 20) begin
            tick();
            cnt++;
            case (which)
                0: begin ack = bus.ack_a; we = bus.ram_we; er = bus.err; rd = bus.rdata_a; addr = bus.ram_addr; end
                1: begin ack = bus.ack_b; we = bus.ram_we; er = bus.err; rd = bus.rdata_b; addr = bus.ram_addr; end
                default: begin ack = sbus.ack_a; we = sbus.ram_we; er = sbus.err; rd = sbus.rdata_a; addr = {14'd0, sbus.ram_addr}; end
            endcase
            if (we) o_we_cnt++;
            if (cnt == 1) o_addr1 = addr;
            if (ack) begin
                seen = 1; o_lat = cnt; o_err = er; o_rd = rd;
            end
        end
        bus.req_a = 1'b0; bus.req_b = 1'b0; sbus.req_a = 1'b0;
        tick();
        case (which)
            0: check("ack_a_one_cycle", bus.ack_a, 1'b0);
            1: check("ack_b_one_cycle", bus.ack_b, 1'b0);
            default: check("small_ack_one_cycle", sbus.ack_a, 1'b0);
        endcase
    endtask

    // Raise both main ports in the same cycle and record ack order.
    task automatic arb_round(input logic [1:0] op, input logic [31:0] wda, input logic [31:0] wdb);
        int cnt;
        int n;
        cnt = 0; n = 0;
        o_first = -1; o_second = -1; o_both = 0; o_first_err = 1'b0;
        bus.req_a = 1'b1; bus.op_a = op; bus.wdata_a = wda;
        bus.req_b = 1'b1; bus.op_b = op; bus.wdata_b = wdb;
        while (n < 2 && cnt < 20) begin
            tick();
            cnt++;
            if (bus.ack_a && bus.ack_b) o_both++;
            if (bus.ack_a) begin
                if (n == 0) begin o_first = 0; o_first_err = bus.err; end else o_second = 0;
                n++; bus.req_a = 1'b0;
            end
            if (bus.ack_b) begin
                if (n == 0) begin o_first = 1; o_first_err = bus.err; end else o_second = 1;
                n++; bus.req_b = 1'b0;
            end
        end
        bus.req_a = 1'b0; bus.req_b = 1'b0;
        tick();
    endtask

    initial begin
        bus.req_a = 1'b0; bus.op_a = OP_ILL; bus.wdata_a = '0;
        bus.req_b = 1'b0; bus.op_b = OP_ILL; bus.wdata_b = '0;
        sbus.req_a = 1'b0; sbus.op_a = OP_ILL; sbus.wdata_a = '0;
        sbus.req_b = 1'b0; sbus.op_b = OP_ILL; sbus.wdata_b = '0;
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        check("rst_state", dbg_state, 3'd0);
        check("rst_sp", bus.sp, 17'd0);
        check("rst_empty", bus.empty, 1'b1);
        check("rst_full", bus.full, 1'b0);
        check("rst_acks", {bus.ack_a, bus.ack_b, bus.err, bus.ram_we}, 4'b0000);
        check("rst_ram_addr", bus.ram_addr, 16'd0);
        check("rst_rdata_a", bus.rdata_a, 32'd0);

        do_op(0, OP_PUSH, 32'h11111111);
        check("push1_lat", o_lat, 2);
        check("push1_err", o_err, 1'b0);
        check("push1_we", o_we_cnt, 1);
        check("push1_addr", o_addr1, 16'd0);
        check("push1_mem", mem[0], 32'h11111111);
        do_op(0, OP_PUSH, 32'h22222222);
        check("push2_lat", o_lat, 2);
        check("push2_addr", o_addr1, 16'd1);
        check("push2_mem", mem[1], 32'h22222222);
        check("push2_sp", bus.sp, 17'd2);
        check("push2_empty", bus.empty, 1'b0);

        do_op(0, OP_POP, 32'h0);
        check("pop_lat", o_lat, 3);
        check("pop_addr", o_addr1, 16'd1);
        check("pop_rd", o_rd, 32'h22222222);
        check("pop_we", o_we_cnt, 0);
        check("pop_sp", bus.sp, 17'd1);
        check("pop_rdata_hold", bus.rdata_a, 32'h22222222);
        do_op(0, OP_PEEK, 32'h0);
        check("peek_lat", o_lat, 3);
        check("peek_addr", o_addr1, 16'd0);
        check("peek_rd", o_rd, 32'h11111111);
        check("peek_sp", bus.sp, 17'd1);

        // The last grant was A, so each round grants B first, then A.
        for (int r = 0; r < 4; r++) begin
            arb_round(OP_PUSH, 32'hA0 + r, 32'hB0 + r);
            check("arb_first_b", o_first, 1);
            check("arb_second_a", o_second, 0);
            check("arb_no_dual_ack", o_both, 0);
        end
        check("arb_sp", bus.sp, 17'd9);

        do_op(1, OP_POP, 32'h0);
        check("popb_lat", o_lat, 3);
        check("popb_rd", o_rd, 32'hA3);
        check("popb_rdata_b", bus.rdata_b, 32'hA3);
        check("popb_rdata_a_hold", bus.rdata_a, 32'h11111111);
        check("popb_sp", bus.sp, 17'd8);

        for (int i = 0; i < 4; i++) begin
            do_op(2, OP_PUSH, 32'hC0 + i);
            check("small_push_lat", o_lat, 2);
            check("small_push_err", o_err, 1'b0);
        end
        check("small_mem3", smem[3], 32'hC3);
        do_op(2, OP_PUSH, 32'hDEAD);
        check("small_ovf_lat", o_lat, 1);
        check("small_ovf_err", o_err, 1'b1);
        check("small_ovf_we", o_we_cnt, 0);
        check("small_full", sbus.full, 1'b1);
        check("small_sp", sbus.sp, 3'd4);

        bus.req_a = 1'b1; bus.op_a = OP_POP;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_state", dbg_state, 3'd0);
        check("midrst_sp", bus.sp, 17'd0);
        check("midrst_ack", bus.ack_a, 1'b0);
        bus.req_a = 1'b0;
        tick();
        check("midrst_no_ack", bus.ack_a, 1'b0);
        rst_n = 1'b1;
        tick();
        check("midrst_empty", bus.empty, 1'b1);

        // Pointer is back to favouring A; PEEK on empty rejects both.
        arb_round(OP_PEEK, 32'h0, 32'h0);
        check("rst_arb_first_a", o_first, 0);
        check("rst_arb_first_err", o_first_err, 1'b1);

        do_op(0, OP_PUSH, 32'h55);
        check("fresh_push_lat", o_lat, 2);
        check("fresh_push_addr", o_addr1, 16'd0);
        check("fresh_push_err", o_err, 1'b0);
        do_op(0, OP_PUSH, 32'h66);
        do_op(0, OP_PUSH, 32'h77);
        do_op(0, OP_POP, 32'h0);
        check("pop77", o_rd, 32'h77);
        do_op(0, OP_POP, 32'h0);
        check("pop66", o_rd, 32'h66);
        check("sp_after_pops", bus.sp, 17'd1);
`ifdef STACK_ARBITER_HWM_EN
        check("hwm", bus.hwm, 17'd3);
`endif
        do_op(0, OP_POP, 32'h0);
        check("pop55", o_rd, 32'h55);
        check("empty_again", bus.empty, 1'b1);

        do_op(0, OP_POP, 32'h0);
        check("unf_lat", o_lat, 1);
        check("unf_err", o_err, 1'b1);
        check("unf_we", o_we_cnt, 0);
        check("unf_sp", bus.sp, 17'd0);
        check("unf_rdata_hold", bus.rdata_a, 32'h55);

        do_op(1, OP_ILL, 32'h0);
        check("ill_b_lat", o_lat, 1);
        check("ill_b_err", o_err, 1'b1);
        check("ill_b_rdata", bus.rdata_b, 32'h0);
        do_op(0, OP_PUSH, 32'h99);
        do_op(0, OP_ILL, 32'h0);
        check("ill_a_lat", o_lat, 1);
        check("ill_a_err", o_err, 1'b1);
        check("ill_a_sp", bus.sp, 17'd1);
        check("ill_a_rdata_hold", bus.rdata_a, 32'h55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
